// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned WORD_W = 32;

  // Memory operation encodings carried on mem_op
  typedef enum logic [OP_W-1:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10
  } mem_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_subword_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, store merge, alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [1:0]        byte_off,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged,
  output logic              misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte/halfword and extend it for loads
  always_comb begin
    sel_byte  = word[{byte_off, 3'b000} +: 8];
    sel_half  = word[{byte_off[1], 4'b0000} +: 16];
    load_data = '0;
    case (op)
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'h000000, sel_byte};
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'h0000, sel_half};
      OP_LW:   load_data = word;
      default: load_data = '0;
    endcase
  end

  // Replace the addressed lane of the old word with the store data
  always_comb begin
    merged = word;
    if (op == OP_SB) begin
      merged[{byte_off, 3'b000} +: 8] = store_data[7:0];
    end else if (op == OP_SH) begin
      merged[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
    end
  end

  // Halfword ops need addr[0]=0, word ops need addr[1:0]=0
  always_comb begin
    misalign = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && byte_off[0]) ||
               (((op == OP_LW) || (op == OP_SW)) && (byte_off != 2'b00));
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: extended loads, aligned word stores, and
// byte/halfword stores done as a two-cycle read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [OP_W-1:0]   mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              flush,
  output logic              dm_mem_read,
  output logic              dm_mem_write,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_write_data,
  input  logic [DATA_W-1:0] dm_read_data,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              misaligned,
  output logic [ADDR_W-1:0] bad_addr
);

  state_e            state;
  state_e            state_next;
  logic [DATA_W-1:0] merge_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] align_load;
  logic [DATA_W-1:0] align_merged;
  logic              align_misalign;
  logic              req_live;
  logic              eff;
  logic              start_rmw;
  logic [ADDR_W-1:0] word_addr;

  lsu_align u_align (
    .op         (mem_op),
    .byte_off   (addr[1:0]),
    .word       (dm_read_data),
    .store_data (store_data),
    .load_data  (align_load),
    .merged     (align_merged),
    .misalign   (align_misalign)
  );

  // Request qualification shared by FSM, outputs and registers
  always_comb begin
    req_live   = req_valid & ~flush;
    misaligned = req_live & align_misalign;
    eff        = req_live & ~align_misalign & (is_load(mem_op) | is_store(mem_op));
    start_rmw  = (state == IDLE) & eff & is_subword_store(mem_op);
    word_addr  = {addr[ADDR_W-1:2], 2'b00};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a sub-word store spends exactly one cycle in RMW_WR
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_rmw) state_next = RMW_WR;
      RMW_WR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side and pipeline outputs per state
  always_comb begin
    dm_mem_read   = 1'b0;
    dm_mem_write  = 1'b0;
    dm_address    = word_addr;
    dm_write_data = '0;
    load_data     = '0;
    stall         = 1'b0;
    case (state)
      IDLE: begin
        if (eff) begin
          if (is_load(mem_op)) begin
            dm_mem_read = 1'b1;
            load_data   = align_load;
          end else if (mem_op == OP_SW) begin
            dm_mem_write  = 1'b1;
            dm_write_data = store_data;
          end else if (is_subword_store(mem_op)) begin
            dm_mem_read = 1'b1;
            stall       = 1'b1;
          end
        end
      end
      RMW_WR: begin
        dm_mem_write  = 1'b1;
        dm_address    = addr_reg;
        dm_write_data = merge_reg;
      end
      default: ;
    endcase
  end

  // Capture merged word/address for the write phase, and the last bad address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      merge_reg <= '0;
      addr_reg  <= '0;
      bad_addr  <= '0;
    end else begin
      if (start_rmw) begin
        merge_reg <= align_merged;
        addr_reg  <= word_addr;
      end
      if (misaligned) begin
        bad_addr <= addr;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        flush;
  logic        dm_mem_read;
  logic        dm_mem_write;
  logic [31:0] dm_address;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;
  logic [31:0] load_data;
  logic        stall;
  logic        misaligned;
  logic [31:0] bad_addr;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .mem_op        (mem_op),
    .addr          (addr),
    .store_data    (store_data),
    .flush         (flush),
    .dm_mem_read   (dm_mem_read),
    .dm_mem_write  (dm_mem_write),
    .dm_address    (dm_address),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data),
    .load_data     (load_data),
    .stall         (stall),
    .misaligned    (misaligned),
    .bad_addr      (bad_addr)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write at posedge
  logic [31:0] mem [0:255];
  assign dm_read_data = mem[dm_address[9:2]];
  always @(posedge clk) if (dm_mem_write) mem[dm_address[9:2]] <= dm_write_data;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_ld_q[$];
  int          total = 0;
  int          bad = 0;
  int          stall_cycles = 0;

  // Apply one request just after a posedge and settle before sampling
  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic fl);
    @(posedge clk);
    #1;
    req_valid  = (op != 4'd0);
    mem_op     = op;
    addr       = a;
    store_data = d;
    flush      = fl;
    #2;
  endtask

  task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    exp_wr_q.push_back({a, d});
    drive(OP_SW, a, d, 1'b0);
    w = exp_wr_q.pop_front();
    total++;
    if (dm_mem_write !== 1'b1 || stall !== 1'b0 || dm_address !== w.a || dm_write_data !== w.d) begin
      bad++;
      $display("FAIL sw_write: wr=%b stall=%b addr=%h data=%h, want wr=1 stall=0 addr=%h data=%h",
               dm_mem_write, stall, dm_address, dm_write_data, w.a, w.d);
    end
  endtask

  task automatic do_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] e;
    exp_ld_q.push_back(exp);
    drive(op, a, 32'h0, 1'b0);
    e = exp_ld_q.pop_front();
    total++;
    if (load_data !== e || stall !== 1'b0 || dm_mem_read !== 1'b1 || dm_mem_write !== 1'b0) begin
      bad++;
      $display("FAIL load op=%0d addr=%h: data=%h stall=%b rd=%b wr=%b, want data=%h stall=0 rd=1 wr=0",
               op, a, load_data, stall, dm_mem_read, dm_mem_write, e);
    end
  endtask

  task automatic do_sub_store(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] exp_word);
    wr_t w;
    exp_wr_q.push_back({a & ~32'h3, exp_word});
    drive(op, a, d, 1'b0);
    stall_cycles += (stall === 1'b1) ? 1 : 0;
    total++;
    if (stall !== 1'b1 || dm_mem_read !== 1'b1 || dm_mem_write !== 1'b0) begin
      bad++;
      $display("FAIL rmw_read addr=%h: stall=%b rd=%b wr=%b, want 1 1 0", a, stall, dm_mem_read, dm_mem_write);
    end
    @(posedge clk);
    #3;
    stall_cycles += (stall === 1'b1) ? 1 : 0;
    w = exp_wr_q.pop_front();
    total++;
    if (dm_mem_write !== 1'b1 || dm_mem_read !== 1'b0 || stall !== 1'b0 ||
        dm_address !== w.a || dm_write_data !== w.d) begin
      bad++;
      $display("FAIL rmw_write: wr=%b rd=%b stall=%b addr=%h data=%h, want 1 0 0 addr=%h data=%h",
               dm_mem_write, dm_mem_read, stall, dm_address, dm_write_data, w.a, w.d);
    end
  endtask

  task automatic test_reset;
    total++;
    if (stall !== 1'b0 || dm_mem_write !== 1'b0 || dm_mem_read !== 1'b0 ||
        load_data !== 32'h0 || misaligned !== 1'b0 || bad_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: stall=%b wr=%b rd=%b ld=%h mis=%b bad=%h, want all zero",
               stall, dm_mem_write, dm_mem_read, load_data, misaligned, bad_addr);
    end
  endtask

  task automatic test_word_fill;
    logic [3:0]  ops [5] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    logic [31:0] ads [5] = '{32'h41, 32'h41, 32'h42, 32'h40, 32'h40};
    logic [31:0] exs [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    do_sw(32'h40, 32'h8899AABB);
    for (int i = 0; i < 5; i++) do_load(ops[i], ads[i], exs[i]);
  endtask

  task automatic test_sb_rmw;
    do_sw(32'h80, 32'h11223344);
    do_sub_store(OP_SB, 32'h82, 32'h000000EE, 32'h11EE3344);
    do_load(OP_LW, 32'h80, 32'h11EE3344);
  endtask

  task automatic test_sh_upper;
    do_sw(32'h84, 32'h00000000);
    do_sub_store(OP_SH, 32'h86, 32'h0000BEEF, 32'hBEEF0000);
    do_load(OP_LW, 32'h84, 32'hBEEF0000);
    do_load(OP_LH, 32'h86, 32'hFFFFBEEF);
  endtask

  task automatic test_misaligned;
    drive(OP_LW, 32'h103, 32'h0, 1'b0);
    total++;
    if (misaligned !== 1'b1 || dm_mem_read !== 1'b0 || dm_mem_write !== 1'b0 || load_data !== 32'h0) begin
      bad++;
      $display("FAIL mis_lw: mis=%b rd=%b wr=%b ld=%h, want 1 0 0 0", misaligned, dm_mem_read, dm_mem_write, load_data);
    end
    drive(OP_SH, 32'h101, 32'h1234, 1'b0);
    total++;
    if (misaligned !== 1'b1 || dm_mem_write !== 1'b0 || stall !== 1'b0 || bad_addr !== 32'h103) begin
      bad++;
      $display("FAIL mis_sh: mis=%b wr=%b stall=%b bad=%h, want 1 0 0 00000103", misaligned, dm_mem_write, stall, bad_addr);
    end
    drive(OP_NONE, 32'h0, 32'h0, 1'b0);
    total++;
    if (bad_addr !== 32'h101 || misaligned !== 1'b0 || dm_mem_write !== 1'b0) begin
      bad++;
      $display("FAIL mis_sticky: bad=%h mis=%b wr=%b, want 00000101 0 0", bad_addr, misaligned, dm_mem_write);
    end
  endtask

  task automatic test_inactive;
    drive(4'd7, 32'h80, 32'hFFFFFFFF, 1'b0);
    total++;
    if (dm_mem_read !== 1'b0 || dm_mem_write !== 1'b0 || stall !== 1'b0 || misaligned !== 1'b0 || load_data !== 32'h0) begin
      bad++;
      $display("FAIL unlisted_op: rd=%b wr=%b stall=%b mis=%b ld=%h, want all zero",
               dm_mem_read, dm_mem_write, stall, misaligned, load_data);
    end
  endtask

  task automatic test_flush;
    drive(OP_SB, 32'h80, 32'h00000077, 1'b1);
    total++;
    if (stall !== 1'b0 || dm_mem_read !== 1'b0 || dm_mem_write !== 1'b0 || misaligned !== 1'b0) begin
      bad++;
      $display("FAIL flush_sb: stall=%b rd=%b wr=%b mis=%b, want 0 0 0 0", stall, dm_mem_read, dm_mem_write, misaligned);
    end
    drive(OP_NONE, 32'h0, 32'h0, 1'b0);
    total++;
    if (dm_mem_write !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_after: wr=%b stall=%b, want 0 0", dm_mem_write, stall);
    end
    do_load(OP_LW, 32'h80, 32'h11EE3344);
  endtask

  task automatic test_reset_mid_rmw;
    do_sw(32'h60, 32'hCAFEF00D);
    drive(OP_SB, 32'h61, 32'h00000055, 1'b0);
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_rmw_stall: stall=%b, want 1", stall);
    end
    @(posedge clk);
    #2;
    total++;
    if (dm_mem_write !== 1'b1) begin
      bad++;
      $display("FAIL rst_rmw_enter: wr=%b, want 1", dm_mem_write);
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    mem_op    = OP_NONE;
    #1;
    total++;
    if (dm_mem_write !== 1'b0 || stall !== 1'b0 || bad_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_rmw_drop: wr=%b stall=%b bad=%h, want 0 0 0", dm_mem_write, stall, bad_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_load(OP_LW, 32'h60, 32'hCAFEF00D);
  endtask

  task automatic test_back_to_back;
    int s0;
    do_sw(32'h20, 32'h00000000);
    s0 = stall_cycles;
    do_sub_store(OP_SB, 32'h20, 32'h00000001, 32'h00000001);
    do_sub_store(OP_SB, 32'h21, 32'h00000002, 32'h00000201);
    total++;
    if (stall_cycles - s0 != 2) begin
      bad++;
      $display("FAIL b2b_stalls: got %0d stall cycles, want 2", stall_cycles - s0);
    end
    do_load(OP_LW, 32'h20, 32'h00000201);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    mem_op     = OP_NONE;
    addr       = 32'h0;
    store_data = 32'h0;
    flush      = 1'b0;
    #12;
    test_reset();
    reset = 1'b0;
    test_word_fill();
    test_sb_rmw();
    test_sh_upper();
    test_misaligned();
    test_inactive();
    test_flush();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage access unit sitting directly upstream of the word-addressed data memory.
- Accepts the EX/MEM memory request (op, byte address, store data).
- Performs byte/halfword/word loads with sign or zero extension.
- Turns byte/halfword stores into a two-cycle read-modify-write of the containing word, stalling the pipeline for one cycle.
- Flags misaligned accesses and suppresses them.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32, no other value supported.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM-stage instruction valid
- mem_op  in  4  access type (package encoding)
- addr  in  32  byte address from ALU
- store_data  in  32  rt value; sub-word stores use the low bits
- flush  in  1  kill current MEM-stage request
- dm_mem_read  out  1  to data memory MemRead
- dm_mem_write  out  1  to data memory MemWrite
- dm_address  out  32  to data memory Address (word-aligned: addr with bits [1:0] cleared)
- dm_write_data  out  32  to data memory WriteData
- dm_read_data  in  32  from data memory ReadData (combinational read)
- load_data  out  32  extended load result to MEM/WB
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- misaligned  out  1  current request misaligned (combinational)
- bad_addr  out  32  last misaligned address (registered, sticky)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Byte order: little-endian. Byte k of a word is bits [8k+7:8k]; halfword 1 is bits [31:16].
- Effective request: eff = req_valid & ~flush & op != NONE & ~misaligned.
- Misaligned condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - misaligned = req_valid & ~flush & condition.
  - No memory access occurs; load_data=0.
  - bad_addr <= addr at the next posedge.
- FSM states: IDLE, RMW_WR.
- IDLE:
  - Load ops: dm_mem_read=1 and load_data driven combinationally from dm_read_data the same cycle. Latency 0, stall=0.
  - SW: dm_mem_write=1, dm_write_data=store_data. Write lands at the posedge, stall=0.
  - SB/SH: dm_mem_read=1, stall=1. The merged word (dm_read_data with the selected byte/half replaced by store_data[7:0]/[15:0]) is latched into merge_reg, and dm_address is latched into addr_reg. Next state RMW_WR.
- RMW_WR:
  - dm_mem_write=1, dm_address=addr_reg, dm_write_data=merge_reg.
  - stall=0, dm_mem_read=0. Next state IDLE.
  - Inputs are ignored in this state: the EX/MEM register was frozen, so the request is still the same store.
  - flush in RMW_WR is ignored; the store commits.
- Load extension:
  - LB sign-extends the selected byte; LBU zero-extends it.
  - LH/LHU do the same on the selected halfword.
  - LW passes the word through.
  - load_data=0 for non-load ops.
- Inactive ops: NONE and any unlisted encoding produce no read, no write, stall=0, misaligned=0.
- Reset values:
  - State IDLE; merge_reg, addr_reg, bad_addr all 0.
  - Outputs: stall=0, dm_mem_write=0, dm_mem_read=0, load_data=0, misaligned=0.
- Reset mid-RMW: state returns to IDLE asynchronously and dm_mem_write drops immediately; the partial store is lost (no write).
- Flush in IDLE with SB/SH: no read, no stall, stay IDLE.
- Back-to-back stores: SB followed by SB to the same word gives the second read the first write's value, because the first write lands at the RMW_WR posedge before the next IDLE read.
- Address range checking is left to the data memory.

Decomposition:
- Package lsu_pkg holds:
  - mem_op encodings: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=8, SH=9, SW=10.
  - State encodings: IDLE=0, RMW_WR=1.
  - Helper functions is_load, is_store, is_subword_store.
- One natural sub-module, lsu_align, which is purely combinational and contains:
  - load extract/extend (op, addr[1:0], word -> load_data);
  - store merge (op, addr[1:0], old word, store_data -> merged word);
  - misalignment check.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Word fill then LB/LBU:
  - Stimulus: SW 0x8899AABB at 0x40, then LB at 0x41, LBU at 0x41, LH at 0x42.
  - Required: load_data 0xFFFFFFAA, 0x000000AA, 0xFFFF8899; stall=0 throughout.
- SB read-modify-write:
  - Stimulus: memory word 0x11223344 at 0x80; SB store_data=0x000000EE at 0x82.
  - Required: stall=1 for exactly one cycle; dm_mem_write high in the next cycle with data 0x11EE3344 at 0x80.
  - Follow-up LW 0x80 returns 0x11EE3344.
- SH upper half:
  - Stimulus: SH 0x0000BEEF at 0x86 over word 0x00000000.
  - Required: word at 0x84 becomes 0xBEEF0000.
- Misaligned accesses:
  - Stimulus: LW at 0x103, then SH at 0x101.
  - Required: misaligned=1, no dm_mem_write, load_data=0; bad_addr=0x103, then 0x101.
- Flush and reset:
  - Stimulus 1: SB with flush=1 in IDLE.
    - Required: no stall, no write.
  - Stimulus 2: reset asserted during RMW_WR.
    - Required: dm_mem_write drops immediately, memory word unchanged, state IDLE, stall=0.
- Back-to-back SB:
  - Stimulus: SB 0x01 at 0x20, then SB 0x02 at 0x21 over word 0.
  - Required: final word 0x00000201 and two one-cycle stalls.
